// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 peripheral; oversamples {cs_n, sclk, mosi}, pulses received bytes, shifts out held bytes.
// Latency: pins to edge detect SYNC_STAGES+1 cycles; miso one cycle after that; rx_valid SYNC_STAGES+2 after 8th sclk rise.
// Backpressure: tx_ready low while a byte is held; no RX backpressure. `SPI_RESPONDER_FRAME_CNT_EN adds frame_cnt.
module spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] spi_i,
    output logic       spi_o,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       underrun,
    output logic       busy
`ifdef SPI_RESPONDER_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Synchronizer chain; cs_n resets low so a frame already in progress at
    // reset release never produces a cs_fall until cs_n has been seen high.
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  sync_last;
    logic                        cs_prev_q, sclk_prev_q, mosi_q;
    logic                        cs_fall_q, cs_rise_q, sclk_rise_q, sclk_fall_q;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Synchronize inputs and register edge detects (mosi kept aligned with them).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '0;
            cs_prev_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_q      <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], spi_i};
            cs_prev_q   <= sync_last[2];
            sclk_prev_q <= sync_last[1];
            mosi_q      <= sync_last[0];
            cs_fall_q   <= cs_prev_q & ~sync_last[2];
            cs_rise_q   <= ~cs_prev_q & sync_last[2];
            sclk_rise_q <= ~sclk_prev_q & sync_last[1];
            sclk_fall_q <= sclk_prev_q & ~sync_last[1];
        end
    end

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       underrun_q, underrun_d;
    logic       spi_o_q, spi_o_d;
    logic       tx_load;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            spi_o_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            spi_o_q     <= spi_o_d;
        end
    end

    // Frame FSM, bit shifting, TX load and holding-register handshake.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        tx_load     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    state_d   = SHIFT;
                    bit_cnt_d = 3'd0;
                    tx_load   = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise_q) begin
                    // Abort or normal end: any partial byte is dropped.
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                end else begin
                    if (sclk_rise_q) begin
                        rx_shift_d = {rx_shift_q[6:0], mosi_q};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = {rx_shift_q[6:0], mosi_q};
                            rx_valid_d = 1'b1;
                        end
                    end
                    if (sclk_fall_q) begin
                        if (bit_cnt_q == 3'd0) begin
                            tx_load = 1'b1;
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The load looks at the registered hold state, so a byte accepted in
        // the same cycle is kept for the following load.
        if (tx_load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d = IDLE_BYTE;
                underrun_d = 1'b1;
            end
        end

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        spi_o_d = (state_d == SHIFT) ? tx_shift_d[7] : 1'b1;
    end

    assign spi_o    = spi_o_q;
    assign tx_ready = ~hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign underrun = underrun_q;
    assign busy     = (state_q == SHIFT);

`ifdef SPI_RESPONDER_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Bytes received in the current/last frame, saturating; cleared at frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= 8'h00;
        end else if (cs_fall_q) begin
            frame_cnt_q <= 8'h00;
        end else if (rx_valid_q && (frame_cnt_q != 8'hFF)) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: bench-side SPI master driving spi_responder with directed and random frames.
// Expected miso bytes, underrun counts and rx bytes come from a per-byte model of the holding register.
// Frames end either with cs_n rising while sclk is high (no trailing load) or after the final sclk fall.
module tb_spi_responder;

    localparam int S    = 2;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cs_n = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic       spi_o;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       underrun;
    logic       busy;
`ifdef SPI_RESPONDER_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    always #5 clk = ~clk;

    spi_responder #(.SYNC_STAGES(S), .IDLE_BYTE(8'hFF)) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_i    ({cs_n, sclk, mosi}),
        .spi_o    (spi_o),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .underrun (underrun),
        .busy     (busy)
`ifdef SPI_RESPONDER_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every rx_valid cycle and count underrun pulses.
    logic [7:0] rx_log [256];
    int         rx_t   [256];
    int         rx_n = 0;
    int         und_n = 0;

    always @(negedge clk) begin
        if (rx_valid && rx_n < 256) begin
            rx_log[rx_n] = rx_data;
            rx_t[rx_n]   = cyc;
            rx_n++;
        end
        if (underrun) und_n++;
    end

    // Frame plan: byte index j is offered (offer_b[j]) before the load that feeds it.
    logic [7:0] mo_b   [4];
    logic [7:0] mi_b   [4];
    int         rise_b [4];
    logic [7:0] offv_b [5];
    bit         offer_b[5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic offer(input logic [7:0] v);
        tx_data  = v;
        tx_valid = 1'b1;
        wait_cyc(1);
        tx_valid = 1'b0;
        chk("tx_ready_held", 32'(tx_ready), 32'd0);
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 5; i++) begin
            offer_b[i] = 1'b0;
            offv_b[i]  = 8'h00;
        end
    endtask

    // style 0: cs_n rises during the last sclk high phase; style 1: after the last fall.
    task automatic run_frame(input int n, input int style, input int abort_bits);
        int rx0, und0, exp_und;
        logic [7:0] e;
        rx0 = rx_n;
        und0 = und_n;
        if (offer_b[0]) offer(offv_b[0]);
        wait_cyc(2);
        cs_n = 1'b0;
        wait_cyc(HALF);
        chk("busy_in_frame", 32'(busy), 32'd1);
`ifdef SPI_RESPONDER_FRAME_CNT_EN
        chk("frame_cnt_clr", 32'(frame_cnt), 32'd0);
`endif
        if (abort_bits > 0) begin
            for (int b = 0; b < abort_bits; b++) begin
                mosi = 1'($urandom_range(0, 1));
                wait_cyc(HALF);
                sclk = 1'b1;
                wait_cyc(HALF);
                sclk = 1'b0;
            end
            wait_cyc(HALF);
            cs_n = 1'b1;
            wait_cyc(2 * HALF);
            chk("abort_no_rx", 32'(rx_n - rx0), 32'd0);
            chk("abort_miso", 32'(spi_o), 32'd1);
            chk("abort_busy", 32'(busy), 32'd0);
`ifdef SPI_RESPONDER_FRAME_CNT_EN
            chk("abort_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
            return;
        end
        for (int k = 0; k < n; k++) begin
            for (int b = 7; b >= 0; b--) begin
                mosi = mo_b[k][b];
                wait_cyc(HALF);
                sclk = 1'b1;
                mi_b[k][b] = spi_o;
                if (b == 0) rise_b[k] = cyc;
                if (k == n - 1 && b == 0 && style == 0) begin
                    wait_cyc(HALF);
                    cs_n = 1'b1;
                    wait_cyc(HALF);
                    sclk = 1'b0;
                end else begin
                    if (b == 4) begin
                        chk("tx_ready_empty", 32'(tx_ready), 32'd1);
                        if (offer_b[k + 1]) begin
                            offer(offv_b[k + 1]);
                            wait_cyc(HALF - 1);
                        end else begin
                            wait_cyc(HALF);
                        end
                    end else begin
                        wait_cyc(HALF);
                    end
                    sclk = 1'b0;
                end
            end
        end
        if (style == 1) begin
            wait_cyc(HALF);
            cs_n = 1'b1;
        end
        mosi = 1'b0;
        wait_cyc(2 * HALF);

        chk("rx_count", 32'(rx_n - rx0), 32'(n));
        for (int k = 0; k < n; k++) begin
            e = offer_b[k] ? offv_b[k] : 8'hFF;
            chk("miso_byte", 32'(mi_b[k]), 32'(e));
            if (rx_n - rx0 > k) begin
                chk("rx_byte", 32'(rx_log[rx0 + k]), 32'(mo_b[k]));
                chk("rx_latency", 32'(rx_t[rx0 + k] - rise_b[k]), 32'(S + 2));
            end
        end
        // One load per byte sent, plus one after the trailing fall in style 1.
        exp_und = 0;
        for (int j = 0; j < n + style; j++) if (!offer_b[j]) exp_und++;
        chk("underrun_count", 32'(und_n - und0), 32'(exp_und));
        chk("tx_ready_end", 32'(tx_ready), 32'd1);
        chk("miso_idle", 32'(spi_o), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
`ifdef SPI_RESPONDER_FRAME_CNT_EN
        chk("frame_cnt_end", 32'(frame_cnt), 32'(n));
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, style, rx0;
        // Reset values.
        wait_cyc(3);
        chk("rst_spi_o", 32'(spi_o), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        wait_cyc(5);

        // Reset during bit 4, released with cs_n still low: frame must be ignored.
        rx0 = rx_n;
        cs_n = 1'b0;
        wait_cyc(HALF);
        for (int b = 0; b < 8; b++) begin
            mosi = 1'($urandom_range(0, 1));
            wait_cyc(HALF);
            sclk = 1'b1;
            if (b == 3) begin
                wait_cyc(1);
                rst = 1'b0;
                wait_cyc(2);
                chk("midrst_spi_o", 32'(spi_o), 32'd1);
                chk("midrst_busy", 32'(busy), 32'd0);
                chk("midrst_rx_data", 32'(rx_data), 32'h00);
                chk("midrst_tx_ready", 32'(tx_ready), 32'd1);
                rst = 1'b1;
                wait_cyc(HALF - 3);
            end else begin
                wait_cyc(HALF);
            end
            sclk = 1'b0;
        end
        wait_cyc(HALF);
        chk("midrst_no_rx", 32'(rx_n - rx0), 32'd0);
        chk("midrst_busy_after", 32'(busy), 32'd0);
        chk("midrst_miso_after", 32'(spi_o), 32'd1);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_cyc(2 * HALF);

        // Single byte with preloaded A5.
        clear_plan();
        offer_b[0] = 1'b1; offv_b[0] = 8'hA5;
        mo_b[0] = 8'h3C;
        run_frame(1, 0, 0);

        // Underrun: two bytes with nothing held.
        clear_plan();
        mo_b[0] = 8'h96; mo_b[1] = 8'h0F;
        run_frame(2, 0, 0);

        // Back-to-back: 11 held, 22 offered while 11 shifts.
        clear_plan();
        offer_b[0] = 1'b1; offv_b[0] = 8'h11;
        offer_b[1] = 1'b1; offv_b[1] = 8'h22;
        mo_b[0] = 8'hC3; mo_b[1] = 8'h5A;
        run_frame(2, 0, 0);

        // Abort after 5 bits, then a clean frame.
        clear_plan();
        run_frame(0, 0, 5);
        clear_plan();
        offer_b[0] = 1'b1; offv_b[0] = 8'h7E;
        mo_b[0] = 8'hE1;
        run_frame(1, 1, 0);

        // Three-byte frame.
        clear_plan();
        mo_b[0] = 8'h01; mo_b[1] = 8'h80; mo_b[2] = 8'hFF;
        offer_b[2] = 1'b1; offv_b[2] = 8'h00;
        run_frame(3, 0, 0);

        // Random frames.
        for (int f = 0; f < 20; f++) begin
            clear_plan();
            n = $urandom_range(1, 3);
            style = $urandom_range(0, 1);
            for (int k = 0; k < n; k++) mo_b[k] = 8'($urandom);
            for (int j = 0; j < n + style; j++) begin
                offer_b[j] = 1'($urandom_range(0, 1));
                offv_b[j]  = 8'($urandom);
            end
            run_frame(n, style, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
